// File: rtl/design_select_ctrl_pkg.sv
// design_sel_pkg: shared constants and FSM state type for the design-select controller.
package design_sel_pkg;
    localparam int NUM_DESIGNS   = 12;
    localparam int ID_W          = 4;
    localparam int GUARD_CYCLES  = 8;
    localparam int SETTLE_CYCLES = 4;
    typedef enum logic [1:0] {IDLE, QUIESCE, SETTLE} sel_state_t;
endpackage

// File: rtl/design_select_ctrl_timer.sv
// sel_timer: loadable down-counter; tc is high while the count sits at zero.
module sel_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) r_cnt <= '0;
        else        r_cnt <= load ? load_val : (tc ? r_cnt : r_cnt - 1'b1);

    assign tc = (r_cnt == '0);
endmodule

// File: rtl/design_select_ctrl.sv
// design_select_ctrl: break-before-make design switch driving the hold-in-reset mask and output mux select.
module design_select_ctrl
    import design_sel_pkg::*;
#(
    parameter int NUM_DESIGNS   = design_sel_pkg::NUM_DESIGNS,
    parameter int ID_W          = design_sel_pkg::ID_W,
    parameter int GUARD_CYCLES  = design_sel_pkg::GUARD_CYCLES,
    parameter int SETTLE_CYCLES = design_sel_pkg::SETTLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  sel_valid,
    input  logic [ID_W-1:0]       sel_id,
    output logic                  sel_ready,
    output logic                  sel_done,
    output logic                  sel_err,
    output logic                  busy,
    output logic [ID_W-1:0]       active_id,
    output logic [ID_W-1:0]       mux_sel,
    output logic [NUM_DESIGNS:1]  designs_cs
);
    localparam int TMR_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [ID_W-1:0] MAX_ID = ID_W'(NUM_DESIGNS);

    sel_state_t          r_state, w_next;
    logic [ID_W-1:0]     r_target;
    logic [NUM_DESIGNS:1] r_cs, w_rel_mask;
    logic [ID_W-1:0]     r_active, r_mux;
    logic                r_done, r_err;
    logic                w_acc, w_bad, w_same, w_start, w_load, w_tc;
    logic [TMR_W-1:0]    w_load_val;

    assign w_acc   = sel_valid && (r_state == IDLE);
    assign w_bad   = sel_id > MAX_ID;
    assign w_same  = sel_id == r_active;
    assign w_start = w_acc && !w_bad && !w_same;

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = TMR_W'(GUARD_CYCLES - 1);
        case (r_state)
            IDLE: if (w_start) begin
                w_next = QUIESCE;
                w_load = 1'b1;
            end
            QUIESCE: if (w_tc) begin
                w_next     = SETTLE;
                w_load     = 1'b1;
                w_load_val = TMR_W'(SETTLE_CYCLES - 1);
            end
            SETTLE: if (w_tc) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Target 0 yields an all-ones mask, i.e. nothing released.
    always_comb begin
        w_rel_mask = '1;
        for (int i = 1; i <= NUM_DESIGNS; i++) w_rel_mask[i] = (r_target != ID_W'(i));
    end

    sel_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (w_load),
        .load_val (w_load_val),
        .tc       (w_tc)
    );

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_cs     <= '1;
            r_active <= '0;
            r_mux    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_acc && w_bad;
            r_done  <= (w_acc && !w_bad && w_same) || (r_state == SETTLE && w_tc);
            if (w_start) begin
                r_target <= sel_id;
                r_cs     <= '1;
                r_active <= '0;
            end
            if (r_state == QUIESCE && w_tc) r_mux <= r_target;
            if (r_state == SETTLE && w_tc) begin
                r_cs     <= w_rel_mask;
                r_active <= r_target;
            end
        end

    assign sel_ready  = (r_state == IDLE);
    assign busy       = ~sel_ready;
    assign sel_done   = r_done;
    assign sel_err    = r_err;
    assign active_id  = r_active;
    assign mux_sel    = r_mux;
    assign designs_cs = r_cs;
endmodule

// File: tb/tb_design_select_ctrl.sv
// tb_design_select_ctrl: directed table of select requests plus held-request and mid-switch reset sequences.
module tb_design_select_ctrl;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        sel_valid;
    logic [3:0]  sel_id;
    logic        sel_ready, sel_done, sel_err, busy;
    logic [3:0]  active_id, mux_sel;
    logic [12:1] designs_cs;
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        logic [3:0]  id;
        logic [12:1] exp_cs;
        logic [3:0]  exp_act;
        logic [3:0]  exp_mux;
        int          kind;
    } vec_t;

    localparam int SWITCH = 0, ERR = 1, SAME = 2;

    design_select_ctrl dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sel_valid  (sel_valid),
        .sel_id     (sel_id),
        .sel_ready  (sel_ready),
        .sel_done   (sel_done),
        .sel_err    (sel_err),
        .busy       (busy),
        .active_id  (active_id),
        .mux_sel    (mux_sel),
        .designs_cs (designs_cs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic req(input vec_t v);
        logic [12:1] cs0;
        logic [3:0]  mux0;
        @(negedge clk);
        cs0       = designs_cs;
        mux0      = mux_sel;
        sel_valid = 1'b1;
        sel_id    = v.id;
        chk("ready_before", 32'(sel_ready), 1);
        @(posedge clk); #1;
        sel_valid = 1'b0;
        if (v.kind != SWITCH) begin
            chk("err_pulse", 32'(sel_err), 32'(v.kind == ERR));
            chk("done_pulse", 32'(sel_done), 32'(v.kind == SAME));
            chk("cs_unchanged", 32'(designs_cs), 32'(cs0));
            chk("mux_unchanged", 32'(mux_sel), 32'(mux0));
            chk("act_unchanged", 32'(active_id), 32'(v.exp_act));
            chk("ready_stays", 32'(sel_ready), 1);
            @(posedge clk); #1;
            chk("err_clear", 32'(sel_err), 0);
            chk("done_clear", 32'(sel_done), 0);
        end else begin
            chk("cs_all_held", 32'(designs_cs), 32'hFFF);
            chk("act_zero", 32'(active_id), 0);
            chk("busy_start", 32'(busy), 1);
            chk("done_early", 32'(sel_done), 0);
            for (int e = 1; e <= 12; e++) begin
                @(posedge clk); #1;
                chk("one_running", 32'($countones(~designs_cs) <= 1), 1);
                if (e == 7) chk("mux_old", 32'(mux_sel), 32'(mux0));
                if (e == 8) chk("mux_new", 32'(mux_sel), 32'(v.exp_mux));
                if (e == 11) begin
                    chk("settle_held", 32'(designs_cs), 32'hFFF);
                    chk("settle_busy", 32'(busy), 1);
                    chk("settle_nodone", 32'(sel_done), 0);
                end
                if (e == 12) begin
                    chk("final_cs", 32'(designs_cs), 32'(v.exp_cs));
                    chk("final_act", 32'(active_id), 32'(v.exp_act));
                    chk("final_done", 32'(sel_done), 1);
                    chk("final_ready", 32'(sel_ready), 1);
                    chk("final_err", 32'(sel_err), 0);
                end
            end
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(sel_done), 0);
            chk("cs_hold", 32'(designs_cs), 32'(v.exp_cs));
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4'd5,  12'hFEF, 4'd5,  4'd5,  SWITCH};
        vecs[1] = '{4'd12, 12'h7FF, 4'd12, 4'd12, SWITCH};
        vecs[2] = '{4'd13, 12'h7FF, 4'd12, 4'd12, ERR};
        vecs[3] = '{4'd15, 12'h7FF, 4'd12, 4'd12, ERR};
        vecs[4] = '{4'd3,  12'hFFB, 4'd3,  4'd3,  SWITCH};
        vecs[5] = '{4'd3,  12'hFFB, 4'd3,  4'd3,  SAME};
        vecs[6] = '{4'd0,  12'hFFF, 4'd0,  4'd0,  SWITCH};

        n_rst     = 1'b0;
        sel_valid = 1'b0;
        sel_id    = '0;
        #12;
        chk("rst_cs", 32'(designs_cs), 32'hFFF);
        chk("rst_act", 32'(active_id), 0);
        chk("rst_mux", 32'(mux_sel), 0);
        chk("rst_ready", 32'(sel_ready), 1);
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_quiet", 32'({sel_done, sel_err, busy}), 0);
        end
        chk("idle_cs", 32'(designs_cs), 32'hFFF);
        chk("idle_mux", 32'(mux_sel), 0);

        foreach (vecs[i]) req(vecs[i]);

        // Held request: ignored while busy, re-accepted in cycle 13 as same-ID.
        @(negedge clk);
        sel_valid = 1'b1;
        sel_id    = 4'd2;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk); #1;
            if (e < 12) chk("held_busy", 32'(busy), 1);
        end
        chk("held_done1", 32'(sel_done), 1);
        chk("held_cs", 32'(designs_cs), 32'hFFD);
        chk("held_act", 32'(active_id), 2);
        @(posedge clk); #1;
        chk("held_done2", 32'(sel_done), 1);
        chk("held_cs2", 32'(designs_cs), 32'hFFD);
        chk("held_ready", 32'(sel_ready), 1);
        sel_valid = 1'b0;
        @(posedge clk); #1;
        chk("held_done_clr", 32'(sel_done), 0);

        // Reset during SETTLE of a switch to 7.
        @(negedge clk);
        sel_valid = 1'b1;
        sel_id    = 4'd7;
        @(posedge clk); #1;
        sel_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_mux", 32'(mux_sel), 7);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_cs", 32'(designs_cs), 32'hFFF);
        chk("arst_act", 32'(active_id), 0);
        chk("arst_mux", 32'(mux_sel), 0);
        chk("arst_ready", 32'(sel_ready), 1);
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", 32'({sel_done, sel_err, busy}), 0);
        end
        chk("post_rst_cs", 32'(designs_cs), 32'hFFF);
        chk("post_rst_act", 32'(active_id), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
